// File: rtl/cpu_sequencer_pkg.sv
// Shared types for the RISC instruction-cycle sequencer: opcodes, state
// encodings, decode flags, the strobe bundle and the per-state strobe table.
package cpu_sequencer_pkg;

    localparam logic [2:0] OP_HLT  = 3'b000;
    localparam logic [2:0] OP_SKZ  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ANDD = 3'b011;
    localparam logic [2:0] OP_XORR = 3'b100;
    localparam logic [2:0] OP_LDA  = 3'b101;
    localparam logic [2:0] OP_STO  = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    // IDLE is "sitting in S0 with strobes off" after reset or while disabled;
    // the next enabled edge enters S0 proper and starts the fetch.
    typedef enum logic [3:0] {
        S0     = 4'd0,
        S1     = 4'd1,
        S2     = 4'd2,
        S3     = 4'd3,
        S4     = 4'd4,
        S5     = 4'd5,
        S6     = 4'd6,
        S7     = 4'd7,
        HALTED = 4'd8,
        IDLE   = 4'd9
    } state_t;

    typedef struct packed {
        logic is_hlt;
        logic is_skz;
        logic is_alu;
        logic is_sto;
        logic is_jmp;
    } dec_t;

    typedef struct packed {
        logic load_ir;
        logic rd;
        logic wr;
        logic inc_pc;
        logic load_pc;
        logic load_acc;
        logic datactl_ena;
        logic halt;
    } strobes_t;

    function automatic strobes_t strobes_for(input state_t st, input dec_t d, input logic zero);
        strobes_t s;
        s = '0;
        case (st)
            S0, S1: begin
                s.load_ir = 1'b1;
                s.rd      = 1'b1;
                s.inc_pc  = 1'b1;
            end
            S3: s.halt = d.is_hlt;
            S4: begin
                s.rd          = d.is_alu;
                s.datactl_ena = d.is_sto;
                s.load_pc     = d.is_jmp;
                s.inc_pc      = d.is_skz & zero;
            end
            S5: begin
                s.rd          = d.is_alu;
                s.load_acc    = d.is_alu;
                s.wr          = d.is_sto;
                s.datactl_ena = d.is_sto;
                s.load_pc     = d.is_jmp;
                s.inc_pc      = d.is_jmp | (d.is_skz & zero);
            end
            S6: begin
                s.rd          = d.is_alu;
                s.datactl_ena = d.is_sto;
            end
            HALTED: s.halt = 1'b1;
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath signal bundle: control inputs from the IR/ALU and
// the datapath strobes produced by the sequencer.
interface cpu_sequencer_if;

    logic       ena;
    logic [2:0] opcode;
    logic       zero;
    logic       load_ir;
    logic       rd;
    logic       wr;
    logic       inc_pc;
    logic       load_pc;
    logic       load_acc;
    logic       datactl_ena;
    logic       halt;

    modport master (
        input  ena, opcode, zero,
        output load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt
    );

    modport slave (
        output ena, opcode, zero,
        input  load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt
    );

endinterface

// File: rtl/cpu_sequencer_seq_decode.sv
// Combinational opcode classifier feeding the sequencer's strobe table.
module seq_decode
    import cpu_sequencer_pkg::*;
#(
    parameter int OPC_W = 3
) (
    input  logic [OPC_W-1:0] opcode,
    output dec_t             dec
);

    localparam int N_OPS = 2 ** OPC_W;

    logic [N_OPS-1:0] op_hot;

    generate
        for (genvar gi = 0; gi < N_OPS; gi++) begin : g_hot
            assign op_hot[gi] = (opcode == OPC_W'(gi));
        end
    endgenerate

    assign dec.is_hlt = op_hot[OP_HLT];
    assign dec.is_skz = op_hot[OP_SKZ];
    assign dec.is_alu = op_hot[OP_ADD] | op_hot[OP_ANDD] | op_hot[OP_XORR] | op_hot[OP_LDA];
    assign dec.is_sto = op_hot[OP_STO];
    assign dec.is_jmp = op_hot[OP_JMP];

endmodule

// File: rtl/cpu_sequencer.sv
// 8-state instruction-cycle controller: state register, next-state logic and
// registered datapath strobes computed from the state being entered.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int OPC_W     = 3,
    parameter bit HLT_STICK = 1'b1
) (
    input  logic              clk1,
    input  logic              rst,
    cpu_sequencer_if.master   bus
);

    state_t   state_reg, state_next;
    strobes_t strobes_reg, strobes_next;
    dec_t     dec;

    seq_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode (bus.opcode[OPC_W-1:0]),
        .dec    (dec)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg   <= IDLE;
            strobes_reg <= '0;
        end else begin
            state_reg   <= state_next;
            strobes_reg <= strobes_next;
        end
    end

    // Strobes are looked up for the state being entered, using opcode/zero
    // as sampled on that same edge, so outputs never depend on inputs combinationally.
    always_comb begin
        state_next   = IDLE;
        strobes_next = '0;
        case (state_reg)
            HALTED: state_next = HALTED;
            IDLE:   state_next = bus.ena ? S0 : IDLE;
            S0, S1, S2, S4, S5, S6: begin
                if (bus.ena) state_next = state_t'(state_reg + 4'd1);
            end
            S3: begin
                if (bus.ena) state_next = (HLT_STICK && dec.is_hlt) ? HALTED : S4;
            end
            S7: begin
                if (bus.ena) state_next = S0;
            end
            default: state_next = IDLE;
        endcase
        strobes_next = strobes_for(state_next, dec, bus.zero);
    end

    assign bus.load_ir     = strobes_reg.load_ir;
    assign bus.rd          = strobes_reg.rd;
    assign bus.wr          = strobes_reg.wr;
    assign bus.inc_pc      = strobes_reg.inc_pc;
    assign bus.load_pc     = strobes_reg.load_pc;
    assign bus.load_acc    = strobes_reg.load_acc;
    assign bus.datactl_ena = strobes_reg.datactl_ena;
    assign bus.halt        = strobes_reg.halt;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: each driven cycle pushes its expected
// strobe vector, which is popped and compared once the clock edge has passed.
`timescale 1ns/1ps
module tb_cpu_sequencer;

    localparam logic [2:0] HLT  = 3'b000;
    localparam logic [2:0] SKZ  = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] ANDD = 3'b011;
    localparam logic [2:0] XORR = 3'b100;
    localparam logic [2:0] LDA  = 3'b101;
    localparam logic [2:0] STO  = 3'b110;
    localparam logic [2:0] JMP  = 3'b111;

    // Vector bit order: {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, halt}
    localparam logic [7:0] V_FETCH = 8'b1101_0000;
    localparam logic [7:0] V_HALT  = 8'b0000_0001;
    localparam logic [7:0] V_NONE  = 8'b0000_0000;

    logic clk1 = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] mask_q[$];
    string      tag_q[$];

    cpu_sequencer_if bus ();

    cpu_sequencer #(.OPC_W(3), .HLT_STICK(1'b1)) dut (
        .clk1 (clk1),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk1 = ~clk1;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_vec(input int k, input logic [2:0] op, input logic z);
        logic alu;
        alu = (op == ADD) || (op == ANDD) || (op == XORR) || (op == LDA);
        case (k)
            0, 1: return V_FETCH;
            3:    return (op == HLT) ? V_HALT : V_NONE;
            4: begin
                if (alu)               return 8'b0100_0000;
                if (op == STO)         return 8'b0000_0010;
                if (op == JMP)         return 8'b0000_1000;
                if (op == SKZ && z)    return 8'b0001_0000;
                return V_NONE;
            end
            5: begin
                if (alu)               return 8'b0100_0100;
                if (op == STO)         return 8'b0010_0010;
                if (op == JMP)         return 8'b0001_1000;
                if (op == SKZ && z)    return 8'b0001_0000;
                return V_NONE;
            end
            6: begin
                if (alu)               return 8'b0100_0000;
                if (op == STO)         return 8'b0000_0010;
                return V_NONE;
            end
            default: return V_NONE;
        endcase
    endfunction

    task automatic drive(input logic r, input logic e, input logic [2:0] op, input logic z,
                         input logic [7:0] exp, input logic [7:0] mask, input string tag);
        logic [7:0] got, e2, m2;
        string      t2;
        rst        = r;
        bus.ena    = e;
        bus.opcode = op;
        bus.zero   = z;
        exp_q.push_back(exp);
        mask_q.push_back(mask);
        tag_q.push_back(tag);
        @(posedge clk1);
        #1;
        got = {bus.load_ir, bus.rd, bus.wr, bus.inc_pc, bus.load_pc,
               bus.load_acc, bus.datactl_ena, bus.halt};
        e2 = exp_q.pop_front();
        m2 = mask_q.pop_front();
        t2 = tag_q.pop_front();
        $display("txn %-14s rst=%b ena=%b op=%03b z=%b out=%b exp=%b",
                 t2, r, e, op, z, got, e2);
        check_eq(t2, got & m2, e2 & m2);
    endtask

    // The inc_pc bit in S7 of a taken SKZ is left unchecked.
    task automatic run_states(input logic [2:0] op, input logic z, input int k_lo,
                              input int k_hi, input string name);
        logic [7:0] mask;
        for (int k = k_lo; k <= k_hi; k++) begin
            mask = (op == SKZ && z && k == 7) ? 8'hEF : 8'hFF;
            drive(1'b0, 1'b1, op, z, exp_vec(k, op, z), mask, $sformatf("%s_s%0d", name, k));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.ena    = 1'b0;
        bus.opcode = ADD;
        bus.zero   = 1'b0;

        drive(1'b1, 1'b0, ADD, 1'b0, V_NONE, 8'hFF, "reset0");
        drive(1'b1, 1'b0, ADD, 1'b0, V_NONE, 8'hFF, "reset1");
        drive(1'b0, 1'b0, ADD, 1'b0, V_NONE, 8'hFF, "disabled");

        run_states(ADD,  1'b0, 0, 7, "add_a");
        run_states(ADD,  1'b0, 0, 7, "add_b");
        run_states(STO,  1'b0, 0, 7, "sto");
        run_states(SKZ,  1'b1, 0, 7, "skz_z1");
        run_states(SKZ,  1'b0, 0, 7, "skz_z0");
        run_states(JMP,  1'b0, 0, 7, "jmp");
        run_states(ANDD, 1'b1, 0, 7, "andd");
        run_states(XORR, 1'b0, 0, 7, "xorr");
        run_states(LDA,  1'b1, 0, 7, "lda");

        for (int i = 0; i < 6; i++) begin
            logic [2:0] op;
            logic       z;
            op = 3'($urandom_range(1, 7));
            z  = 1'($urandom_range(0, 1));
            run_states(op, z, 0, 7, $sformatf("rnd%0d", i));
        end

        // Reset mid-instruction: STO aborted at the edge that would enter S5.
        run_states(STO, 1'b0, 0, 4, "sto_abort");
        drive(1'b1, 1'b1, STO, 1'b0, V_NONE, 8'hFF, "rst_in_s5");
        run_states(ADD, 1'b0, 0, 7, "after_rst");

        // Enable dropped at the edge that would enter S3.
        run_states(ADD, 1'b0, 0, 2, "ena_drop");
        drive(1'b0, 1'b0, ADD, 1'b0, V_NONE, 8'hFF, "ena0_s3");
        run_states(STO, 1'b0, 0, 7, "resume");

        // Sticky halt: ena/opcode scrambled while parked.
        run_states(HLT, 1'b0, 0, 3, "hlt");
        drive(1'b0, 1'b1, HLT, 1'b0, V_HALT, 8'hFF, "halted0");
        for (int i = 1; i < 20; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), V_HALT, 8'hFF, $sformatf("halted%0d", i));
        end
        drive(1'b1, 1'b1, ADD, 1'b0, V_NONE, 8'hFF, "rst_halt");
        run_states(JMP, 1'b0, 0, 7, "post_halt");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
